clock_div_ctrl: RTL and testbench

Sequencing controller and arbiter for the integer-N clock divider. Accepts divide-value change requests from two requesters (management SoC register, housekeeping SPI), picks one by round-robin, and drives the divider's `N` input through a gate → load → settle → ungate sequence so the divided clock never glitches downstream. Runs in the divider's input-clock domain and sits between the housekeeping/CSR logic and `clock_div` plus its downstream clock gate.

---
 rtl/clock_div_ctrl_pkg.sv | 23 ++
 rtl/clock_div_ctrl_rr_arb2.sv | 26 ++
 rtl/clock_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_clock_div_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/clock_div_ctrl_pkg.sv
// Shared types and constants for the clock divider sequencing controller.
package clock_div_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGate,
    StLoad,
    StSettle,
    StDone
  } cdc_state_e;

  localparam int unsigned CDC_RESET_N = 2;

  // Worst-case divider period is 2*(2^size - 1) plus a margin of two cycles.
  function automatic int unsigned settle_min(input int unsigned size);
    return 2 * ((32'd1 << size) - 1) + 2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/clock_div_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past the winner on each advance.
module rr_arb2 (
  input  logic       clock,
  input  logic       resetb,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic r_prefer;

  always_comb begin
    grant_idx = (req == 2'b11) ? r_prefer : req[1];
    grant     = (|req) ? (2'b01 << grant_idx) : 2'b00;
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_prefer <= 1'b0;
    end else if (advance && (|req)) begin
      r_prefer <= ~grant_idx;
    end
  end

endmodule

// File: rtl/clock_div_ctrl.sv
// Arbitrates divide-value requests and walks the divider through gate, load, settle, ungate.
module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter int unsigned SIZE      = 3,
  parameter int unsigned RESET_N   = CDC_RESET_N,
  parameter int unsigned GATE_WAIT = 2,
  parameter int unsigned SETTLE    = 16
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic [1:0]        req,
  input  logic [2*SIZE-1:0] req_n,
  output logic [1:0]        ack,
  output logic [1:0]        err,
  output logic [SIZE-1:0]   div_n,
  output logic              gate_en,
  output logic              busy,
  output logic              owner
);

  // A too-short settle window is stretched to the worst-case divider period.
  localparam int unsigned SettleEff =
      (SETTLE < settle_min(SIZE)) ? settle_min(SIZE) : SETTLE;
  localparam int unsigned CntW = cnt_width(GATE_WAIT, SettleEff);

  cdc_state_e      r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [SIZE-1:0] r_pend, w_pend_d;
  logic [SIZE-1:0] r_div, w_div_d;
  logic            r_gate, w_gate_d;
  logic            r_busy, w_busy_d;
  logic            r_owner, w_owner_d;
  logic [1:0]      r_ack, w_ack_d;
  logic [1:0]      r_err, w_err_d;

  logic            w_advance;
  logic [1:0]      w_grant;
  logic            w_grant_idx;
  logic [SIZE-1:0] w_sel_n;

  assign w_advance = (r_state == StIdle) && (|req);
  assign w_sel_n   = w_grant_idx ? req_n[2*SIZE-1:SIZE] : req_n[SIZE-1:0];

  rr_arb2 u_arb (
    .clock     (clock),
    .resetb    (resetb),
    .req       (req),
    .advance   (w_advance),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pend_d  = r_pend;
    w_div_d   = r_div;
    w_gate_d  = r_gate;
    w_busy_d  = r_busy;
    w_owner_d = r_owner;
    w_ack_d   = 2'b00;
    w_err_d   = 2'b00;
    unique case (r_state)
      StIdle: begin
        if (w_advance) begin
          w_owner_d = w_grant_idx;
          w_pend_d  = w_sel_n;
          // N=1 would pin the divider output low, so it is refused outright.
          if (w_sel_n == SIZE'(1)) begin
            w_err_d = w_grant;
          end else if (w_sel_n == r_div) begin
            w_ack_d = w_grant;
          end else begin
            w_state_d = StGate;
            w_gate_d  = 1'b0;
            w_busy_d  = 1'b1;
            w_cnt_d   = CntW'(GATE_WAIT - 1);
          end
        end
      end
      StGate: begin
        if (r_cnt == '0) begin
          w_state_d = StLoad;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StLoad: begin
        w_div_d   = r_pend;
        w_cnt_d   = CntW'(SettleEff - 1);
        w_state_d = StSettle;
      end
      StSettle: begin
        if (r_cnt == '0) begin
          w_state_d = StDone;
          w_gate_d  = 1'b1;
          w_ack_d   = 2'b01 << r_owner;
        end else begin
          w_cnt_d = r_cnt - CntW'(1);
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_pend  <= SIZE'(RESET_N);
      r_div   <= SIZE'(RESET_N);
      r_gate  <= 1'b1;
      r_busy  <= 1'b0;
      r_owner <= 1'b0;
      r_ack   <= 2'b00;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pend  <= w_pend_d;
      r_div   <= w_div_d;
      r_gate  <= w_gate_d;
      r_busy  <= w_busy_d;
      r_owner <= w_owner_d;
      r_ack   <= w_ack_d;
      r_err   <= w_err_d;
    end
  end

  assign ack     = r_ack;
  assign err     = r_err;
  assign div_n   = r_div;
  assign gate_en = r_gate;
  assign busy    = r_busy;
  assign owner   = r_owner;

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Directed bench for clock_div_ctrl with hand-computed cycle expectations.
module tb_clock_div_ctrl;

  logic       clock = 1'b0;
  logic       resetb;
  logic [1:0] req;
  logic [5:0] req_n;
  logic [1:0] ack;
  logic [1:0] err;
  logic [2:0] div_n;
  logic       gate_en;
  logic       busy;
  logic       owner;

  int n_tests = 0;
  int n_fail  = 0;

  clock_div_ctrl #(
    .SIZE      (3),
    .RESET_N   (2),
    .GATE_WAIT (2),
    .SETTLE    (16)
  ) dut (
    .clock   (clock),
    .resetb  (resetb),
    .req     (req),
    .req_n   (req_n),
    .ack     (ack),
    .err     (err),
    .div_n   (div_n),
    .gate_en (gate_en),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clock = ~clock;

  // After tick() returns, the values seen are those registered at the edge just taken.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req    = 2'b00;
    resetb = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
  endtask

  // Request(s) already driven; grant happens at the next edge (cycle 0).
  task automatic expect_seq(input logic [1:0] g, input logic [2:0] nv, input logic [2:0] old,
                            input string tag);
    int         bad;
    logic [2:0] prev;
    bad  = 0;
    prev = div_n;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (gate_en && (div_n !== prev)) bad++;
      if ((c < 20) && ((ack !== 2'b00) || (err !== 2'b00) || (gate_en !== 1'b0))) bad++;
      prev = div_n;
      if (c == 1) begin
        chk({tag, "_busy1"}, {7'd0, busy}, 8'd1);
        chk({tag, "_owner1"}, {7'd0, owner}, {7'd0, g[1]});
      end
      if (c == 3) chk({tag, "_div3"}, {5'd0, div_n}, {5'd0, old});
      if (c == 4) chk({tag, "_div4"}, {5'd0, div_n}, {5'd0, nv});
      if (c == 20) begin
        chk({tag, "_ack20"}, {6'd0, ack}, {6'd0, g});
        chk({tag, "_gate20"}, {7'd0, gate_en}, 8'd1);
      end
    end
    chk({tag, "_glitch"}, bad[7:0], 8'd0);
    req = req & ~g;
  endtask

  initial begin
    int bad;
    req_n = 6'd0;
    do_reset();

    // Reset state and a long idle stretch.
    chk("rst_div", {5'd0, div_n}, 8'd2);
    chk("rst_gate", {7'd0, gate_en}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ackerr", {4'd0, ack, err}, 8'd0);
    chk("rst_owner", {7'd0, owner}, 8'd0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ((div_n !== 3'd2) || (gate_en !== 1'b1) || (busy !== 1'b0) || (ack !== 2'b00)) bad++;
    end
    chk("idle_hold", bad[7:0], 8'd0);

    // Single change from requester 0.
    req_n = {3'd0, 3'd5};
    req   = 2'b01;
    expect_seq(2'b01, 3'd5, 3'd2, "r0_5");
    tick();
    chk("r0_5_busy21", {7'd0, busy}, 8'd0);
    chk("r0_5_ack21", {6'd0, ack}, 8'd0);

    // Both requesting from reset: 0 first, then 1.
    do_reset();
    req_n = {3'd6, 3'd3};
    req   = 2'b11;
    expect_seq(2'b01, 3'd3, 3'd2, "both_a");
    tick();
    chk("both_busy21", {7'd0, busy}, 8'd0);
    expect_seq(2'b10, 3'd6, 3'd3, "both_b");
    chk("both_owner", {7'd0, owner}, 8'd1);
    tick();

    // Same-value request: immediate ack, no gating; requester 0 becomes last granted.
    req_n = {3'd6, 3'd6};
    req   = 2'b01;
    tick();
    chk("same_ack", {6'd0, ack}, 8'd1);
    chk("same_gate", {7'd0, gate_en}, 8'd1);
    chk("same_busy", {7'd0, busy}, 8'd0);
    req = 2'b00;

    // Repeat of both: served 1 then 0.
    req_n = {3'd4, 3'd7};
    req   = 2'b11;
    expect_seq(2'b10, 3'd4, 3'd6, "rep_a");
    tick();
    expect_seq(2'b01, 3'd7, 3'd4, "rep_b");
    tick();

    // Illegal N=1 from requester 1.
    req_n = {3'd1, 3'd0};
    req   = 2'b10;
    tick();
    chk("rej_err", {6'd0, err}, 8'd2);
    chk("rej_ack", {6'd0, ack}, 8'd0);
    chk("rej_div", {5'd0, div_n}, 8'd7);
    chk("rej_gate", {7'd0, gate_en}, 8'd1);
    chk("rej_busy", {7'd0, busy}, 8'd0);
    req = 2'b00;
    tick();
    chk("rej_err_clr", {6'd0, err}, 8'd0);

    // Reset in the middle of SETTLE abandons the sequence.
    do_reset();
    req_n = {3'd0, 3'd7};
    req   = 2'b01;
    for (int c = 1; c <= 10; c++) tick();
    chk("mid_div10", {5'd0, div_n}, 8'd7);
    resetb = 1'b0;
    tick();
    resetb = 1'b1;
    chk("mid_div", {5'd0, div_n}, 8'd2);
    chk("mid_gate", {7'd0, gate_en}, 8'd1);
    chk("mid_busy", {7'd0, busy}, 8'd0);
    chk("mid_ack", {6'd0, ack}, 8'd0);
    expect_seq(2'b01, 3'd7, 3'd2, "after_rst");
    tick();

    // N=0 (bypass) is a normal change.
    req_n = {3'd0, 3'd0};
    req   = 2'b01;
    expect_seq(2'b01, 3'd0, 3'd7, "zero");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
